breadboard_sweep_ctrl: RTL and testbench

- Sequencer for the 4-input / 10-output combinational truth-table block used in the ALU Part 1 logic-gate stage.
- Drives the block's {w,x,y,z} inputs through a programmable range of vectors and waits a settle time before sampling each response.
- Streams each captured response out over a valid/ready handshake and folds it into a 16-bit signature, so on-board and bench checks need one compare instead of 16.

---
 rtl/breadboard_sweep_ctrl.sv | 117 +++++++++++
 tb/tb_breadboard_sweep_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/breadboard_sweep_ctrl.sv
// Sweeps the {w,x,y,z} inputs of the 4-in/10-out truth-table block over a
// programmable index range and streams each settled response with a running signature.
module breadboard_sweep_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned SIG_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       first,
  input  logic [3:0]       last,
  output logic [3:0]       vec,
  input  logic [9:0]       resp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_index,
  output logic [9:0]       res_data,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t             state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic [3:0]         last_q, last_n;
  logic [3:0]         vec_n, idx_n;
  logic [9:0]         data_n;
  logic               valid_n, busy_n, done_n;
  logic [SIG_W-1:0]   sig_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_q;
    vec_n   = vec;
    idx_n   = res_index;
    data_n  = res_data;
    valid_n = res_valid;
    sig_n   = signature;

    case (state)
      IDLE: begin
        if (start) begin
          last_n  = last;
          vec_n   = first;
          cnt_n   = SETTLE_CNT;
          sig_n   = '0;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          data_n  = resp;
          idx_n   = vec;
          valid_n = 1'b1;
          sig_n   = {signature[SIG_W-2:0], signature[SIG_W-1]} ^ SIG_W'(resp);
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (res_valid && res_ready) begin
          valid_n = 1'b0;
          if (vec == last_q) begin
            state_n = DONE;
          end else begin
            vec_n   = vec + 4'd1;
            cnt_n   = SETTLE_CNT;
            state_n = DRIVE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // busy/done are registered from the next state so they line up with it
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_q    <= '0;
      vec       <= '0;
      res_valid <= 1'b0;
      res_index <= '0;
      res_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_q    <= last_n;
      vec       <= vec_n;
      res_valid <= valid_n;
      res_index <= idx_n;
      res_data  <= data_n;
      busy      <= busy_n;
      done      <= done_n;
      signature <= sig_n;
    end
  end

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Directed and randomized sweeps of breadboard_sweep_ctrl, checked against a
// queue-based reference of the expected index order, response data and signature.
module tb_breadboard_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  first, last;
  logic [3:0]  vec;
  logic [9:0]  resp;
  logic        res_valid, res_ready;
  logic [3:0]  res_index;
  logic [9:0]  res_data;
  logic        busy, done;
  logic [15:0] signature;

  logic [9:0]  tt [16];
  int          tests = 0;
  int          fails = 0;

  assign resp = tt[vec];

  always #5 clk = ~clk;

  breadboard_sweep_ctrl #(.SETTLE(2), .SIG_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .first(first), .last(last),
    .vec(vec), .resp(resp), .res_valid(res_valid), .res_ready(res_ready),
    .res_index(res_index), .res_data(res_data), .busy(busy), .done(done),
    .signature(signature)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [9:0] d);
    return ((s << 1) | (s >> 15)) ^ {6'b0, d};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) tt[i] = 10'($urandom);
  endtask

  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input int pct,
                           input int hold, input bit poke);
    logic [3:0]  exp_q[$];
    logic [3:0]  e, p_idx, p_vec;
    logic [9:0]  p_data;
    logic [15:0] sig_m;
    int          n, got, done_cnt, hold_left, cyc;
    bit          poked, prev_wait, acc_prev;

    n = ((int'(l) - int'(f)) & 15) + 1;
    for (int k = 0; k < n; k++) exp_q.push_back(4'(int'(f) + k));
    sig_m = '0; got = 0; done_cnt = 0; hold_left = hold;
    poked = 0; prev_wait = 0; acc_prev = 0;
    p_idx = '0; p_vec = '0; p_data = '0;

    @(negedge clk);
    start = 1'b1; first = f; last = l;
    @(negedge clk);
    start = 1'b0; first = 4'($urandom); last = 4'($urandom);
    chk("busy_after_start", busy, 1);
    chk("vec_after_start", vec, f);

    for (cyc = 0; cyc < 2000; cyc++) begin
      start = 1'b0;
      if (acc_prev) begin
        chk("valid_drop_after_accept", res_valid, 0);
        if (exp_q.size() != 0) chk("vec_advance", vec, exp_q[0]);
        else chk("vec_hold_at_last", vec, l);
      end
      if (prev_wait) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_index", res_index, p_idx);
        chk("hold_data", res_data, p_data);
        chk("hold_vec", vec, p_vec);
      end
      if (done) begin
        done_cnt++;
        chk("busy_during_done", busy, 1);
        chk("sig_at_done", signature, sig_m);
        chk("all_results_before_done", exp_q.size(), 0);
      end
      if (done_cnt > 0 && !busy && !done) break;

      if (poke && !poked && busy && !res_valid && !done) begin
        start = 1'b1; first = 4'd9; last = 4'd9; poked = 1;
      end
      if (res_valid && hold_left > 0) begin
        res_ready = 1'b0;
        hold_left--;
      end else begin
        res_ready = ($urandom_range(0, 99) < pct);
      end

      acc_prev  = res_valid && res_ready;
      prev_wait = res_valid && !res_ready;
      if (res_valid) chk("vec_eq_index", vec, res_index);
      if (acc_prev) begin
        if (exp_q.size() == 0) begin
          chk("result_count_over", got + 1, n);
        end else begin
          e = exp_q.pop_front();
          chk("res_index", res_index, e);
          chk("res_data", res_data, tt[e]);
          sig_m = sig_step(sig_m, tt[e]);
          got++;
        end
      end
      p_idx = res_index; p_data = res_data; p_vec = vec;
      @(negedge clk);
    end

    chk("sweep_terminated", cyc < 2000, 1);
    chk("result_count", got, n);
    chk("done_once", done_cnt, 1);
    chk("sig_final", signature, sig_m);
    chk("busy_idle", busy, 0);
    chk("vec_kept", vec, l);
    res_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [3:0] rf, rl;

    reset = 1'b1; start = 1'b0; first = '0; last = '0; res_ready = 1'b0;
    for (int i = 0; i < 16; i++) tt[i] = 10'h155;
    tick(); tick();
    chk("rst_vec", vec, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_index", res_index, 0);
    chk("rst_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 0);
    reset = 1'b0;

    // single vector, exact cycle timing from the accepting edge S
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; first = 4'd3; last = 4'd3;
    tick();
    start = 1'b0;
    chk("sv_vec_S", vec, 3);
    chk("sv_busy_S", busy, 1);
    chk("sv_valid_S", res_valid, 0);
    tick(); chk("sv_valid_S1", res_valid, 0);
    tick(); chk("sv_valid_S2", res_valid, 0);
    tick();
    chk("sv_valid_S3", res_valid, 1);
    chk("sv_index_S3", res_index, 3);
    chk("sv_data_S3", res_data, 10'h155);
    tick();
    chk("sv_valid_S4", res_valid, 0);
    chk("sv_done_S4", done, 1);
    chk("sv_busy_S4", busy, 1);
    chk("sv_sig_S4", signature, 16'h0155);
    tick();
    chk("sv_done_S5", done, 0);
    chk("sv_busy_S5", busy, 0);
    chk("sv_sig_S5", signature, 16'h0155);
    chk("sv_vec_S5", vec, 3);
    res_ready = 1'b0;

    // truth-table vector 0
    fill_random();
    tt[0] = 10'h194;
    run_sweep(4'd0, 4'd0, 100, 0, 0);
    chk("tt_vec0_data", res_data, 10'h194);

    // wrap 14..1 with resp = vec
    for (int i = 0; i < 16; i++) tt[i] = 10'(i);
    run_sweep(4'd14, 4'd1, 100, 0, 0);

    // backpressure
    fill_random();
    run_sweep(4'd2, 4'd4, 100, 5, 0);

    // start while busy
    fill_random();
    run_sweep(4'd0, 4'd2, 60, 0, 1);

    // full sweep and random ranges
    fill_random();
    run_sweep(4'd0, 4'd15, 70, 2, 0);
    for (int r = 0; r < 6; r++) begin
      fill_random();
      rf = 4'($urandom); rl = 4'($urandom);
      run_sweep(rf, rl, 50, $urandom_range(0, 3), r[0]);
    end

    // reset during EMIT of index 5
    fill_random();
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; first = 4'd0; last = 4'd15;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 500; cyc++) begin
      if (res_valid && res_index == 4'd5) break;
      @(negedge clk);
    end
    chk("reached_index5", cyc < 500, 1);
    res_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_vec", vec, 0);
    chk("mrst_valid", res_valid, 0);
    chk("mrst_index", res_index, 0);
    chk("mrst_data", res_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sig", signature, 0);
    reset = 1'b0;
    run_sweep(4'd7, 4'd7, 80, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
